// File: rtl/lz4_output_fifo_if.sv
// lz4_output_fifo_if: push/pop handshake, status and statistics bundle for the decompressor output FIFO
interface lz4_output_fifo_if #(
  parameter int word_size = 8,
  parameter int depth = 16,
  parameter int addr_size = $clog2(depth)
);
  logic [word_size-1:0] uncompressed_word;
  logic data_valid;
  logic out_ready;
  logic [word_size-1:0] out_word;
  logic out_valid;
  logic full;
  logic empty;
  logic [addr_size:0] count;
  logic overflow;
  logic [15:0] bytes_out;
  modport master (
    output uncompressed_word, data_valid, out_ready,
    input out_word, out_valid, full, empty, count, overflow, bytes_out
  );
  modport slave (
    input uncompressed_word, data_valid, out_ready,
    output out_word, out_valid, full, empty, count, overflow, bytes_out
  );
endinterface

// File: rtl/lz4_output_fifo.sv
// lz4_output_fifo: first-word-fall-through FIFO buffering decompressed words with drop detection and pop counter
module lz4_output_fifo #(
  parameter int word_size = 8,
  parameter int depth = 16,
  parameter int addr_size = $clog2(depth)
) (
  input logic clk,
  input logic reset,
  lz4_output_fifo_if.slave f
);
  logic [word_size-1:0] mem [depth];
  logic [addr_size-1:0] rd_ptr, wr_ptr;
  logic [addr_size:0] count;
  logic [15:0] bytes_out;
  logic overflow, push, pop, full, empty;
  always_comb begin
    empty = count == '0;
    full = count == (addr_size+1)'(depth);
    pop = !empty && f.out_ready;
    push = f.data_valid && (!full || pop);
  end
  assign f.out_word = empty ? '0 : mem[rd_ptr];
  assign f.out_valid = !empty;
  assign f.full = full;
  assign f.empty = empty;
  assign f.count = count;
  assign f.overflow = overflow;
  assign f.bytes_out = bytes_out;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= f.uncompressed_word;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      bytes_out <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + addr_size'(1);
      if (pop) bytes_out <= bytes_out + 16'd1;
      if (push) wr_ptr <= wr_ptr + addr_size'(1);
      count <= count + (addr_size+1)'(push) - (addr_size+1)'(pop);
      if (f.data_valid && !push) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_lz4_output_fifo.sv
// tb_lz4_output_fifo: randomized and directed checks of the output FIFO against a queue model
module tb_lz4_output_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  lz4_output_fifo_if #(.word_size(8), .depth(DEPTH), .addr_size(4)) f();
  lz4_output_fifo #(.word_size(8), .depth(DEPTH), .addr_size(4)) dut (.clk(clk), .reset(reset), .f(f));
  always #10 clk = ~clk;
  logic [7:0] mq [$];
  logic [7:0] got [$];
  logic m_ovf = 1'b0;
  logic [15:0] m_bytes = '0;
  int n_push = 0;
  task automatic chk(input string n, input longint a, input longint e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_bytes = '0;
    end else begin
      logic pop, push;
      pop = mq.size() > 0 && f.out_ready === 1'b1;
      push = f.data_valid === 1'b1 && (mq.size() < DEPTH || pop);
      if (f.data_valid === 1'b1 && !push) m_ovf = 1'b1;
      if (pop) begin
        got.push_back(mq.pop_front());
        m_bytes = m_bytes + 16'd1;
      end
      if (push) begin
        mq.push_back(f.uncompressed_word);
        n_push++;
      end
    end
  end
  always @(negedge clk) if (!reset) begin
    chk("out_valid", f.out_valid, mq.size() > 0);
    chk("out_word", f.out_word, mq.size() > 0 ? mq[0] : 0);
    chk("count", f.count, mq.size());
    chk("full", f.full, mq.size() == DEPTH);
    chk("empty", f.empty, mq.size() == 0);
    chk("overflow", f.overflow, m_ovf);
    chk("bytes_out", f.bytes_out, m_bytes);
  end
  task automatic cyc(input logic dv, input logic [7:0] w, input logic rdy);
    #2;
    f.data_valid = dv;
    f.uncompressed_word = w;
    f.out_ready = rdy;
    @(negedge clk);
  endtask
  task automatic drain();
    for (int g = 0; g < 64 && mq.size() > 0; g++) cyc(1'b0, 8'd0, 1'b1);
    chk("drain_done", mq.size(), 0);
  endtask
  task automatic pulse_reset();
    #3;
    f.data_valid = 1'b0;
    f.out_ready = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_count", f.count, 0);
    chk("rst_empty", f.empty, 1);
    chk("rst_full", f.full, 0);
    chk("rst_valid", f.out_valid, 0);
    chk("rst_word", f.out_word, 0);
    chk("rst_overflow", f.overflow, 0);
    chk("rst_bytes", f.bytes_out, 0);
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    int base, ok;
    logic tog;
    f.data_valid = 1'b0;
    f.out_ready = 1'b0;
    f.uncompressed_word = '0;
    repeat (2) @(negedge clk);
    chk("init_empty", f.empty, 1);
    chk("init_count", f.count, 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'd49, 1'b0);
    chk("r31_count", f.count, 5);
    chk("r31_word", f.out_word, 49);
    chk("r31_valid", f.out_valid, 1);
    got.delete();
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'd0, 1'b1);
    chk("r31_npop", got.size(), 5);
    ok = 1;
    foreach (got[i]) if (got[i] != 8'd49) ok = 0;
    chk("r31_values", ok, 1);
    chk("r31_empty", f.empty, 1);
    chk("r31_bytes", f.bytes_out, 5);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
    chk("r32_full", f.full, 1);
    chk("r32_count", f.count, 16);
    chk("r32_ovf0", f.overflow, 0);
    cyc(1'b1, 8'd99, 1'b0);
    chk("r32_ovf1", f.overflow, 1);
    chk("r32_count2", f.count, 16);
    got.delete();
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'd0, 1'b1);
    ok = got.size() == 16;
    foreach (got[i]) if (got[i] != 8'(i)) ok = 0;
    chk("r32_order", ok, 1);
    chk("r32_empty", f.empty, 1);
    pulse_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(200 + i), 1'b0);
    got.delete();
    cyc(1'b1, 8'd77, 1'b1);
    chk("r33_count", f.count, 16);
    chk("r33_full", f.full, 1);
    chk("r33_ovf", f.overflow, 0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'd0, 1'b1);
    chk("r33_npop", got.size(), 17);
    chk("r33_last", got[$], 77);
    chk("r33_empty", f.empty, 1);
    cyc(1'b1, 8'd50, 1'b1);
    chk("r34_valid", f.out_valid, 1);
    chk("r34_word", f.out_word, 50);
    chk("r34_count", f.count, 1);
    drain();
    got.delete();
    base = n_push;
    tog = 1'b0;
    for (int g = 0; g < 500 && n_push - base < 40; g++) begin
      cyc(mq.size() < DEPTH, 8'(100 + n_push - base), tog);
      tog = ~tog;
    end
    drain();
    ok = got.size() == 40;
    foreach (got[i]) if (got[i] != 8'(100 + i)) ok = 0;
    chk("r35_order", ok, 1);
    chk("r35_ovf", f.overflow, 0);
    for (int i = 0; i < 600; i++) begin
      int pv, pr;
      pv = (i / 100) % 2 ? 75 : 40;
      pr = (i / 100) % 2 ? 30 : 70;
      cyc($urandom_range(0, 99) < pv, 8'($urandom), $urandom_range(0, 99) < pr);
    end
    drain();
    pulse_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, 8'(i + 1), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'd0, 1'b1);
    chk("r36_pre_count", f.count, 6);
    chk("r36_pre_ovf", f.overflow, 1);
    pulse_reset();
    got.delete();
    cyc(1'b1, 8'd51, 1'b0);
    chk("r36_count", f.count, 1);
    chk("r36_word", f.out_word, 51);
    cyc(1'b0, 8'd0, 1'b1);
    chk("r36_npop", got.size(), 1);
    chk("r36_only", got[0], 51);
    chk("r36_empty", f.empty, 1);
    cyc(1'b0, 8'd0, 1'b1);
    chk("r36_nostale", f.out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lz4_output_fifo.md
LZ4_OUTPUT_FIFO -- requirements
Module: lz4_output_fifo

Interface
REQ-001 Parameter word_size, default 8, width of every data word in bits.
REQ-002 Parameter depth, default 16, number of storage entries; SHALL be a power of two, at least 2.
REQ-003 Parameter addr_size, default log2(depth) = 4, width of the read and write pointers.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 uncompressed_word  input  word_size  decompressed byte from the LZ4Decompressor uncompressed_word output.
REQ-007 data_valid  input  1  push strobe from the LZ4Decompressor data_valid output; one word per high cycle.
REQ-008 out_ready  input  1  downstream consumer accepts out_word this cycle.
REQ-009 out_word  output  word_size  head-of-queue word.
REQ-010 out_valid  output  1  out_word holds a valid entry.
REQ-011 full  output  1  count equals depth.
REQ-012 empty  output  1  count equals 0.
REQ-013 count  output  addr_size+1  number of entries currently stored.
REQ-014 overflow  output  1  sticky flag: at least one pushed word was dropped.
REQ-015 bytes_out  output  16  running total of words popped.

Function
REQ-016 The block SHALL be a first-word-fall-through FIFO: out_word = mem[rd_ptr] combinationally when not empty, and 0 when empty.
REQ-017 out_valid SHALL equal NOT empty; full and empty SHALL be derived combinationally from count.
REQ-018 pop SHALL occur when out_valid AND out_ready; on a pop rd_ptr increments modulo depth and bytes_out increments.
REQ-019 push SHALL occur when data_valid AND (NOT full OR pop); on a push uncompressed_word is written to mem[wr_ptr] and wr_ptr increments modulo depth.
REQ-020 count next = count + push - pop; a simultaneous push and pop SHALL leave count unchanged.
REQ-021 data_valid while full with no pop SHALL drop the word, leave pointers and count unchanged, and set overflow the next edge.
REQ-022 overflow SHALL stay at 1 until reset.
REQ-023 data_valid while empty with out_ready high SHALL push only; the new word appears on out_word the following cycle, giving 1-cycle push-to-out_valid latency.
REQ-024 A pop while full with data_valid high SHALL accept the push in the same cycle; full stays 1.
REQ-025 Pointers SHALL wrap from depth-1 to 0 with no gap or repeated entry.
REQ-026 bytes_out SHALL wrap from 65535 to 0 without affecting any other state.
REQ-027 out_ready while empty SHALL have no effect.

Reset
REQ-028 While reset is high, rd_ptr, wr_ptr, count, overflow and bytes_out SHALL be 0 immediately, independent of clk; empty=1, full=0, out_valid=0, out_word=0.
REQ-029 Memory contents SHALL NOT be reset; entries written before reset SHALL never be presented afterwards.
REQ-030 Reset asserted mid-operation SHALL discard all queued words; operation resumes on the first rising edge after reset deasserts.

Verification
REQ-031 Push 49,49,49,49,49 with out_ready=0 -> count=5, out_word=49, out_valid=1; then out_ready=1 for 5 cycles -> five 49s out, empty=1, bytes_out=5.
REQ-032 Push 0..15 (depth 16), no pops -> full=1, count=16; push 99 -> dropped, overflow=1, count=16; drain -> 0..15 in order, 99 absent.
REQ-033 Full FIFO with data_valid=1 (word 77) and out_ready=1 in the same cycle -> count stays 16, overflow stays 0, 77 emerges last after 16 pops.
REQ-034 Empty FIFO, data_valid=1 (word 50) with out_ready=1 -> no pop that cycle; next cycle out_valid=1, out_word=50, count=1.
REQ-035 Push 40 words with out_ready toggling every cycle -> output sequence identical to input, pointers wrap at least twice, no overflow.
REQ-036 Queue holds 6 words and overflow=1; pulse reset between clock edges -> count=0, empty=1, overflow=0, bytes_out=0 asynchronously; the next push of 51 appears as the only word.
